// File: rtl/tdm_demux_1x4.sv
// Receive side of a 4-channel TDM link: aligns on the frame-sync marker, stages
// four words and publishes each complete frame with a one-cycle valid pulse.
module tdm_demux_1x4 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sync,
    input  logic [WIDTH-1:0]   in_data,
    output logic [4*WIDTH-1:0] out_data,
    output logic               out_valid,
    output logic [1:0]         ch_sel,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ctr_q, ctr_d;
    logic [3:0][WIDTH-1:0]   stg_q, stg_d;
    logic [4*WIDTH-1:0]      out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    sync_err_q, sync_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            ctr_q       <= 2'd0;
            stg_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            stg_q       <= stg_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        stg_d       = stg_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        stg_d[0] = in_data;
                        ctr_d    = 2'd1;
                        state_d  = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sync) begin
                        // Early sync abandons the partial frame and restarts at slot 0.
                        sync_err_d = (ctr_q != 2'd0);
                        stg_d[0]   = in_data;
                        ctr_d      = 2'd1;
                    end else if (ctr_q == 2'd0) begin
                        sync_err_d = 1'b1;
                        ctr_d      = 2'd0;
                        state_d    = HUNT;
                    end else begin
                        stg_d[ctr_q] = in_data;
                        ctr_d        = ctr_q + 2'd1;
                        if (ctr_q == 2'd3) begin
                            out_data_d  = {in_data, stg_q[2], stg_q[1], stg_q[0]};
                            out_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        locked    = (state_q == LOCK);
        ch_sel    = ctr_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        sync_err  = sync_err_q;
    end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: directed scenarios plus random traffic, all checked
// against a queue-based frame model.
module tb_tdm_demux_1x4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  ch_sel;
    logic        locked;
    logic        sync_err;

    int total = 0;
    int bad = 0;

    // model state: alignment flag, words collected for the current frame
    bit          aligned = 1'b0;
    logic [7:0]  q[$];
    logic [31:0] m_data = '0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;

    tdm_demux_1x4 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sync(in_sync),
        .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .ch_sel(ch_sel), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] exp_vec();
        return {m_valid, m_err, logic'(aligned), 2'(q.size()), m_data};
    endfunction

    // drive one cycle, advance the model on the same edge, then settle
    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d);
        rst_n = r; in_valid = v; in_sync = s; in_data = d;
        @(posedge clk);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!r) begin
            aligned = 1'b0; q.delete(); m_data = '0;
        end else if (v) begin
            if (!aligned) begin
                if (s) begin aligned = 1'b1; q.delete(); q.push_back(d); end
            end else if (s) begin
                m_err = (q.size() != 0);
                q.delete(); q.push_back(d);
            end else if (q.size() == 0) begin
                m_err = 1'b1; aligned = 1'b0;
            end else begin
                q.push_back(d);
                if (q.size() == 4) begin
                    m_data = {q[3], q[2], q[1], q[0]};
                    m_valid = 1'b1;
                    q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== 37'd0) begin
                bad++;
                $display("FAIL reset got=%h exp=0", {out_valid, sync_err, locked, ch_sel, out_data});
            end
        end
    endtask

    task automatic test_clean();
        logic [7:0] w[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        int nerr = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, (i % 4) == 0, w[i]);
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL clean[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
            if (sync_err) nerr++;
            if (i == 0) begin
                total++;
                if (locked !== 1'b1) begin bad++; $display("FAIL clean_lock got=%b exp=1", locked); end
            end
            if (i == 3 || i == 7) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== (i == 3 ? 32'h44332211 : 32'h88776655)) begin
                    bad++;
                    $display("FAIL clean_frame%0d got=%b/%h", i / 4, out_valid, out_data);
                end
            end
        end
        total++;
        if (nerr != 0) begin bad++; $display("FAIL clean_noerr got=%0d exp=0", nerr); end
    endtask

    task automatic test_hunt();
        logic [7:0] w[6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, i == 2, w[i]);
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL hunt[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h04030201) begin
            bad++; $display("FAIL hunt_frame got=%b/%h exp=1/04030201", out_valid, out_data);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] prev = out_data;
        int nval = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, i == 0, 8'hC0 + 8'(i));
            if (out_valid) nval++;
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL gap_word[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
            if (i == 3) break;
            for (int g = 0; g < 3; g++) begin
                step(1'b1, 1'b0, 1'b0, 8'($urandom));
                if (out_valid) nval++;
                total++;
                if (ch_sel !== 2'(i + 1) || out_data !== prev) begin
                    bad++; $display("FAIL gap_hold got=%0d/%h exp=%0d/%h", ch_sel, out_data, i + 1, prev);
                end
            end
        end
        total++;
        if (nval != 1 || out_data !== 32'hC3C2C1C0) begin
            bad++; $display("FAIL gap_frame got=%0d/%h exp=1/c3c2c1c0", nval, out_data);
        end
    endtask

    task automatic test_early_sync();
        logic [7:0] w[6] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        int nval = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, i == 0 || i == 2, w[i]);
            if (out_valid) nval++;
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL early[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
            if (i == 2) begin
                total++;
                if (sync_err !== 1'b1 || out_valid !== 1'b0) begin
                    bad++; $display("FAIL early_err got=%b/%b exp=1/0", sync_err, out_valid);
                end
            end
        end
        total++;
        if (nval != 1 || out_data !== 32'h60504030) begin
            bad++; $display("FAIL early_frame got=%0d/%h exp=1/60504030", nval, out_data);
        end
    endtask

    task automatic test_missing_sync();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 8'hE0 + 8'(i));
        step(1'b1, 1'b1, 1'b0, 8'h99);
        total++;
        if (sync_err !== 1'b1 || locked !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'hE3E2E1E0) begin
            bad++;
            $display("FAIL missing got=%b/%b/%b/%h exp=1/0/0/e3e2e1e0", sync_err, locked, out_valid, out_data);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00);
        total++;
        if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
            bad++; $display("FAIL missing_after got=%h exp=%h", {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 1'b0, 8'hA2);
        step(1'b0, 1'b1, 1'b0, 8'hA3);
        total++;
        if ({out_valid, sync_err, locked, ch_sel, out_data} !== 37'd0) begin
            bad++; $display("FAIL rst_mid got=%h exp=0", {out_valid, sync_err, locked, ch_sel, out_data});
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 8'hB1 + 8'(i));
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hB4B3B2B1) begin
            bad++; $display("FAIL rst_mid_frame got=%b/%h exp=1/b4b3b2b1", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0, 8'($urandom));
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int nval = 0;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, (i % 4) == 0, 8'(i * 7 + 3));
            if (out_valid) nval++;
            total++;
            if ({out_valid, sync_err, locked, ch_sel, out_data} !== exp_vec()) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, {out_valid, sync_err, locked, ch_sel, out_data}, exp_vec());
            end
        end
        total++;
        if (nval != 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", nval); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_hunt();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
